// File: rtl/register_file_scoreboard_pkg.sv
// Shared widths and constants for the integer register file,
// write-back and decode stages.
package register_file_scoreboard_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int REGISTER_COUNT = 32;
    localparam logic [4:0] ZERO_REGISTER = 5'd0;

endpackage

// File: rtl/register_file_scoreboard_if.sv
// Write-back commit bundle: rd index, data and commit strobe.
interface register_file_scoreboard_if
    import register_file_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W
) ();

    logic [ADDR_WIDTH-1:0] RD_ADDRESS_IN;
    logic [DATA_WIDTH-1:0] RD_DATA_IN;
    logic                  RD_WRITE_ENABLE_IN;

    modport master (
        output RD_ADDRESS_IN,
        output RD_DATA_IN,
        output RD_WRITE_ENABLE_IN
    );

    modport slave (
        input RD_ADDRESS_IN,
        input RD_DATA_IN,
        input RD_WRITE_ENABLE_IN
    );

endinterface

// File: rtl/register_file_scoreboard_load_scoreboard.sv
// Busy bits for destinations of outstanding loads and the decode stall.
// REGISTER_FILE_DEBUG_PORT_EN adds a combinational busy-bit peek.
module load_scoreboard
    import register_file_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    input  logic                  rs1_en_i,
    input  logic                  rs2_en_i,
    input  logic                  rs1_hit_i,
    input  logic                  rs2_hit_i,
    input  logic                  wb_en_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic                  issue_i,
    input  logic [ADDR_WIDTH-1:0] issue_addr_i,
    input  logic                  kill_i,
    input  logic [ADDR_WIDTH-1:0] kill_addr_i,
`ifdef REGISTER_FILE_DEBUG_PORT_EN
    input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
    output logic                  dbg_busy_o,
`endif
    output logic                  stall_o
);

    localparam int NREG = 2**ADDR_WIDTH;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clears first, then set: a younger issuing load wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_en_i) busy_d[wb_addr_i] = 1'b0;
        if (kill_i)  busy_d[kill_addr_i] = 1'b0;
        if (issue_i) busy_d[issue_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign stall_o =
        (rs1_en_i && busy_q[rs1_addr_i] && !rs1_hit_i) ||
        (rs2_en_i && busy_q[rs2_addr_i] && !rs2_hit_i);

`ifdef REGISTER_FILE_DEBUG_PORT_EN
    assign dbg_busy_o = busy_q[dbg_addr_i];
`endif

endmodule

// File: rtl/register_file_scoreboard.sv
// x0..x31 register file with write-to-read bypass and load scoreboard.
// REGISTER_FILE_DEBUG_PORT_EN adds an unbypassed debug read port.
module register_file_scoreboard
    import register_file_scoreboard_pkg::*;
#(
    parameter int   DATA_WIDTH = DATA_W,
    parameter int   ADDR_WIDTH = ADDR_W,
    parameter logic HIGH       = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [ADDR_WIDTH-1:0] RS1_ADDRESS,
    input  logic [ADDR_WIDTH-1:0] RS2_ADDRESS,
    input  logic                  RS1_READ_ENABLE,
    input  logic                  RS2_READ_ENABLE,
    output logic [DATA_WIDTH-1:0] RS1_DATA,
    output logic [DATA_WIDTH-1:0] RS2_DATA,
    register_file_scoreboard_if.slave WB,
    input  logic                  LOAD_ISSUE,
    input  logic [ADDR_WIDTH-1:0] LOAD_RD_ADDRESS,
    input  logic                  LOAD_KILL,
    input  logic [ADDR_WIDTH-1:0] LOAD_KILL_ADDRESS,
`ifdef REGISTER_FILE_DEBUG_PORT_EN
    input  logic [ADDR_WIDTH-1:0] DEBUG_ADDRESS,
    output logic [DATA_WIDTH-1:0] DEBUG_DATA,
    output logic                  DEBUG_BUSY,
`endif
    output logic                  STALL_OUT
);

    localparam int NREG = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] X0 =
        ADDR_WIDTH'(ZERO_REGISTER);

    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic wr_en;
    logic hit1;
    logic hit2;

    assign wr_en = (WB.RD_WRITE_ENABLE_IN == HIGH) &&
                   (WB.RD_ADDRESS_IN != X0);
    assign hit1  = wr_en && (WB.RD_ADDRESS_IN == RS1_ADDRESS);
    assign hit2  = wr_en && (WB.RD_ADDRESS_IN == RS2_ADDRESS);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[WB.RD_ADDRESS_IN] <= WB.RD_DATA_IN;
        end
    end

    always_comb begin
        RS1_DATA = regs_q[RS1_ADDRESS];
        if (RS1_ADDRESS == X0) RS1_DATA = '0;
        if (hit1)              RS1_DATA = WB.RD_DATA_IN;
        RS2_DATA = regs_q[RS2_ADDRESS];
        if (RS2_ADDRESS == X0) RS2_DATA = '0;
        if (hit2)              RS2_DATA = WB.RD_DATA_IN;
    end

`ifdef REGISTER_FILE_DEBUG_PORT_EN
    assign DEBUG_DATA = (DEBUG_ADDRESS == X0) ?
                        '0 : regs_q[DEBUG_ADDRESS];
`endif

    load_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sb (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .rs1_addr_i   (RS1_ADDRESS),
        .rs2_addr_i   (RS2_ADDRESS),
        .rs1_en_i     (RS1_READ_ENABLE),
        .rs2_en_i     (RS2_READ_ENABLE),
        .rs1_hit_i    (hit1),
        .rs2_hit_i    (hit2),
        .wb_en_i      (wr_en),
        .wb_addr_i    (WB.RD_ADDRESS_IN),
        .issue_i      (LOAD_ISSUE),
        .issue_addr_i (LOAD_RD_ADDRESS),
        .kill_i       (LOAD_KILL),
        .kill_addr_i  (LOAD_KILL_ADDRESS),
`ifdef REGISTER_FILE_DEBUG_PORT_EN
        .dbg_addr_i   (DEBUG_ADDRESS),
        .dbg_busy_o   (DEBUG_BUSY),
`endif
        .stall_o      (STALL_OUT)
    );

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard; exercises the
// debug port when REGISTER_FILE_DEBUG_PORT_EN is defined.
module tb_register_file_scoreboard;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [4:0]  RS1_ADDRESS;
    logic [4:0]  RS2_ADDRESS;
    logic        RS1_READ_ENABLE;
    logic        RS2_READ_ENABLE;
    logic [31:0] RS1_DATA;
    logic [31:0] RS2_DATA;
    logic        LOAD_ISSUE;
    logic [4:0]  LOAD_RD_ADDRESS;
    logic        LOAD_KILL;
    logic [4:0]  LOAD_KILL_ADDRESS;
    logic        STALL_OUT;
`ifdef REGISTER_FILE_DEBUG_PORT_EN
    logic [4:0]  DEBUG_ADDRESS;
    logic [31:0] DEBUG_DATA;
    logic        DEBUG_BUSY;
`endif

    int vecs = 0;
    int errs = 0;

    register_file_scoreboard_if wb ();

    register_file_scoreboard dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .RS1_ADDRESS       (RS1_ADDRESS),
        .RS2_ADDRESS       (RS2_ADDRESS),
        .RS1_READ_ENABLE   (RS1_READ_ENABLE),
        .RS2_READ_ENABLE   (RS2_READ_ENABLE),
        .RS1_DATA          (RS1_DATA),
        .RS2_DATA          (RS2_DATA),
        .WB                (wb.slave),
        .LOAD_ISSUE        (LOAD_ISSUE),
        .LOAD_RD_ADDRESS   (LOAD_RD_ADDRESS),
        .LOAD_KILL         (LOAD_KILL),
        .LOAD_KILL_ADDRESS (LOAD_KILL_ADDRESS),
`ifdef REGISTER_FILE_DEBUG_PORT_EN
        .DEBUG_ADDRESS     (DEBUG_ADDRESS),
        .DEBUG_DATA        (DEBUG_DATA),
        .DEBUG_BUSY        (DEBUG_BUSY),
`endif
        .STALL_OUT         (STALL_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wb_set(input logic en,
                          input logic [4:0] a,
                          input logic [31:0] d);
        wb.RD_WRITE_ENABLE_IN = en;
        wb.RD_ADDRESS_IN = a;
        wb.RD_DATA_IN = d;
    endtask

    initial begin
        RST_N = 1'b0;
        RS1_ADDRESS = '0;
        RS2_ADDRESS = '0;
        RS1_READ_ENABLE = 1'b0;
        RS2_READ_ENABLE = 1'b0;
        LOAD_ISSUE = 1'b0;
        LOAD_RD_ADDRESS = '0;
        LOAD_KILL = 1'b0;
        LOAD_KILL_ADDRESS = '0;
`ifdef REGISTER_FILE_DEBUG_PORT_EN
        DEBUG_ADDRESS = '0;
`endif
        wb_set(1'b0, 5'd0, 32'h0);
        #2;
        check("rst_rs1", RS1_DATA, 32'h0);
        check("rst_stall", {31'b0, STALL_OUT}, 32'h0);
        step();
        RST_N = 1'b1;
        step();

        // write x5 then reset asynchronously mid-cycle
        wb_set(1'b1, 5'd5, 32'hDEADBEEF);
        step();
        wb_set(1'b0, 5'd0, 32'h0);
        RS1_ADDRESS = 5'd5;
        #1;
        check("x5_written", RS1_DATA, 32'hDEADBEEF);
        RST_N = 1'b0;
        #1;
        check("async_rst_rs1", RS1_DATA, 32'h0);
        check("async_rst_stall", {31'b0, STALL_OUT}, 32'h0);
        step();
        RST_N = 1'b1;
        step();

        // write x7, read back next cycle
        wb_set(1'b1, 5'd7, 32'h12345678);
        step();
        wb_set(1'b0, 5'd0, 32'h0);
        RS2_ADDRESS = 5'd7;
        #1;
        check("x7_rs2", RS2_DATA, 32'h12345678);

        // x0 write ignored, no bypass either
        RS1_ADDRESS = 5'd0;
        wb_set(1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        check("x0_no_bypass", RS1_DATA, 32'h0);
        step();
        wb_set(1'b0, 5'd0, 32'h0);
        #1;
        check("x0_read", RS1_DATA, 32'h0);

`ifdef REGISTER_FILE_DEBUG_PORT_EN
        DEBUG_ADDRESS = 5'd7;
        #1;
        check("dbg_x7_data", DEBUG_DATA, 32'h12345678);
        check("dbg_x7_busy", {31'b0, DEBUG_BUSY}, 32'h0);
`endif

        // same-cycle bypass on both ports
        RS1_ADDRESS = 5'd9;
        RS2_ADDRESS = 5'd9;
        wb_set(1'b1, 5'd9, 32'hA5A5A5A5);
        #1;
        check("bypass_rs1", RS1_DATA, 32'hA5A5A5A5);
        check("bypass_rs2", RS2_DATA, 32'hA5A5A5A5);
        step();
        wb_set(1'b0, 5'd0, 32'h0);
        #1;
        check("x9_stored", RS2_DATA, 32'hA5A5A5A5);

        // load-use stall on x3
        LOAD_ISSUE = 1'b1;
        LOAD_RD_ADDRESS = 5'd3;
        step();
        LOAD_ISSUE = 1'b0;
        RS1_ADDRESS = 5'd3;
        RS1_READ_ENABLE = 1'b0;
        #1;
        check("no_stall_en0", {31'b0, STALL_OUT}, 32'h0);
        RS1_READ_ENABLE = 1'b1;
        #1;
        check("stall_x3", {31'b0, STALL_OUT}, 32'h1);
        wb_set(1'b1, 5'd3, 32'h55);
        #1;
        check("wb_resolves", {31'b0, STALL_OUT}, 32'h0);
        check("wb_bypass_x3", RS1_DATA, 32'h55);
        step();
        wb_set(1'b0, 5'd0, 32'h0);
        #1;
        check("x3_cleared", {31'b0, STALL_OUT}, 32'h0);
        check("x3_stored", RS1_DATA, 32'h55);
        RS1_READ_ENABLE = 1'b0;

        // issue and write-back same edge: set wins
        LOAD_ISSUE = 1'b1;
        LOAD_RD_ADDRESS = 5'd4;
        wb_set(1'b1, 5'd4, 32'h44);
        step();
        LOAD_ISSUE = 1'b0;
        wb_set(1'b0, 5'd0, 32'h0);
        RS2_ADDRESS = 5'd4;
        RS2_READ_ENABLE = 1'b1;
        #1;
        check("set_wins", {31'b0, STALL_OUT}, 32'h1);
`ifdef REGISTER_FILE_DEBUG_PORT_EN
        DEBUG_ADDRESS = 5'd4;
        #1;
        check("dbg_busy4", {31'b0, DEBUG_BUSY}, 32'h1);
`endif
        LOAD_KILL = 1'b1;
        LOAD_KILL_ADDRESS = 5'd4;
        step();
        LOAD_KILL = 1'b0;
        #1;
        check("kill_clears", {31'b0, STALL_OUT}, 32'h0);
        RS2_READ_ENABLE = 1'b0;

        // x0 is never marked busy
        LOAD_ISSUE = 1'b1;
        LOAD_RD_ADDRESS = 5'd0;
        step();
        LOAD_ISSUE = 1'b0;
        RS1_ADDRESS = 5'd0;
        RS1_READ_ENABLE = 1'b1;
        #1;
        check("x0_never_busy", {31'b0, STALL_OUT}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
